// File: rtl/sophon_trace_buf_pkg.sv
// Shared types and helpers for the probe trace buffer: capture FSM encoding
// and the masked trigger compare.
package sophon_trace_buf_pkg;

   localparam int MAX_W = 512;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ARMED     = 3'd1,
      ST_WAIT_TRIG = 3'd2,
      ST_POST      = 3'd3,
      ST_DONE      = 3'd4
   } state_e;

   // Operands are zero-extended to MAX_W by the caller, so unused upper bits never mismatch.
   function automatic logic match_f(input logic [MAX_W-1:0] probe,
                                    input logic [MAX_W-1:0] val,
                                    input logic [MAX_W-1:0] mask);
      return (((probe ^ val) & mask) == {MAX_W{1'b0}});
   endfunction

endpackage

// File: rtl/sophon_trace_ram.sv
// Simple dual-port trace RAM: one write port, one read port with a registered
// output that holds its value when no read is requested.
module sophon_trace_ram
   import sophon_trace_buf_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem_r [DEPTH];

   // Storage array: no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Read port output register; the reset only touches this register.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= {W{1'b0}};
      end else if (re) begin
         rdata <= mem_r[raddr];
      end
   end

endmodule

// File: rtl/sophon_trace_buf.sv
// Probe trace buffer: circular capture of a debug vector around a programmable
// trigger, with chronological readout by logical index once the capture is done.
module sophon_trace_buf
   import sophon_trace_buf_pkg::*;
#(
   parameter int PROBE_W = 150,
   parameter int DEPTH   = 1024,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [PROBE_W-1:0] probe_i,
   input  logic               sample_en_i,
   input  logic               arm_i,
   input  logic               abort_i,
   input  logic               force_trig_i,
   input  logic [PROBE_W-1:0] trig_mask_i,
   input  logic [PROBE_W-1:0] trig_val_i,
   input  logic               trig_edge_i,
   input  logic [AW-1:0]      pre_cnt_i,
   input  logic               rd_req_i,
   input  logic [AW-1:0]      rd_idx_i,
   output logic               rd_valid_o,
   output logic [PROBE_W-1:0] rd_data_o,
   output logic [2:0]         state_o,
   output logic               done_o,
   output logic [AW-1:0]      trig_idx_o
);

   localparam logic [AW-1:0] ZERO_A = {AW{1'b0}};
   localparam logic [AW-1:0] ONE_A  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);

   state_e        state_r, state_s;
   logic [AW-1:0] wp_r, wp_s;
   logic [AW-1:0] fill_r, fill_s;
   logic [AW-1:0] pre_r, pre_s;
   logic [AW-1:0] post_r, post_s;
   logic [AW-1:0] trig_ptr_r, trig_ptr_s;
   logic          prev_match_r, prev_match_s;
   logic          prev_valid_r, prev_valid_s;
   logic          done_r, rd_valid_r;
   logic [AW-1:0] trig_idx_r;
   logic          we_s, re_s, hit_s, trig_s;
   logic [AW-1:0] raddr_s;
   logic [MAX_W-1:0] probe_x_s, val_x_s, mask_x_s;

   // Widen the compare operands to the package function's fixed width.
   always_comb begin
      probe_x_s = {MAX_W{1'b0}};
      val_x_s   = {MAX_W{1'b0}};
      mask_x_s  = {MAX_W{1'b0}};
      probe_x_s[PROBE_W-1:0] = probe_i;
      val_x_s[PROBE_W-1:0]   = trig_val_i;
      mask_x_s[PROBE_W-1:0]  = trig_mask_i;
   end

   // Trigger event: level or first-match-after-mismatch, or forced.
   always_comb begin
      hit_s  = match_f(probe_x_s, val_x_s, mask_x_s);
      trig_s = force_trig_i |
               (trig_edge_i ? (prev_valid_r & ~prev_match_r & hit_s) : hit_s);
   end

   // Capture FSM next state, pointer updates and RAM write strobe.
   always_comb begin
      state_s      = state_r;
      wp_s         = wp_r;
      fill_s       = fill_r;
      pre_s        = pre_r;
      post_s       = post_r;
      trig_ptr_s   = trig_ptr_r;
      prev_match_s = prev_match_r;
      prev_valid_s = prev_valid_r;
      we_s         = 1'b0;
      if (abort_i) begin
         state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (arm_i) begin
                  state_s      = ST_ARMED;
                  // pre_cnt_i is AW bits wide, so it never exceeds DEPTH-1.
                  pre_s        = pre_cnt_i;
                  wp_s         = ZERO_A;
                  fill_s       = ZERO_A;
                  prev_match_s = 1'b0;
                  prev_valid_s = 1'b0;
               end else begin
                  state_s = state_r;
               end
            end
            ST_ARMED: begin
               if (pre_r == ZERO_A) begin
                  state_s = ST_WAIT_TRIG;
               end else if (sample_en_i) begin
                  we_s         = 1'b1;
                  wp_s         = wp_r + ONE_A;
                  fill_s       = fill_r + ONE_A;
                  prev_match_s = hit_s;
                  prev_valid_s = 1'b1;
                  // The last pre sample is never a trigger, even if it matches.
                  state_s      = ((fill_r + ONE_A) == pre_r) ? ST_WAIT_TRIG : ST_ARMED;
               end else begin
                  state_s = ST_ARMED;
               end
            end
            ST_WAIT_TRIG: begin
               if (sample_en_i) begin
                  we_s         = 1'b1;
                  wp_s         = wp_r + ONE_A;
                  prev_match_s = hit_s;
                  prev_valid_s = 1'b1;
                  if (trig_s) begin
                     trig_ptr_s = wp_r;
                     post_s     = LAST_A - pre_r;
                     state_s    = ((LAST_A - pre_r) == ZERO_A) ? ST_DONE : ST_POST;
                  end else begin
                     state_s = ST_WAIT_TRIG;
                  end
               end else begin
                  state_s = ST_WAIT_TRIG;
               end
            end
            ST_POST: begin
               if (sample_en_i) begin
                  we_s         = 1'b1;
                  wp_s         = wp_r + ONE_A;
                  post_s       = post_r - ONE_A;
                  prev_match_s = hit_s;
                  prev_valid_s = 1'b1;
                  state_s      = (post_r == ONE_A) ? ST_DONE : ST_POST;
               end else begin
                  state_s = ST_POST;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // Readout maps logical index 0 onto the oldest stored sample.
   always_comb begin
      re_s    = rd_req_i & (state_r == ST_DONE);
      raddr_s = trig_ptr_r - pre_r + rd_idx_i;
   end

   // State, pointer and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r      <= ST_IDLE;
         wp_r         <= ZERO_A;
         fill_r       <= ZERO_A;
         pre_r        <= ZERO_A;
         post_r       <= ZERO_A;
         trig_ptr_r   <= ZERO_A;
         prev_match_r <= 1'b0;
         prev_valid_r <= 1'b0;
         done_r       <= 1'b0;
         trig_idx_r   <= ZERO_A;
         rd_valid_r   <= 1'b0;
      end else begin
         state_r      <= state_s;
         wp_r         <= wp_s;
         fill_r       <= fill_s;
         pre_r        <= pre_s;
         post_r       <= post_s;
         trig_ptr_r   <= trig_ptr_s;
         prev_match_r <= prev_match_s;
         prev_valid_r <= prev_valid_s;
         done_r       <= (state_s == ST_DONE);
         trig_idx_r   <= (state_s == ST_DONE) ? pre_s : ZERO_A;
         rd_valid_r   <= re_s;
      end
   end

   sophon_trace_ram #(
      .W     (PROBE_W),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk_i),
      .rst   (rst_i),
      .we    (we_s),
      .waddr (wp_r),
      .wdata (probe_i),
      .re    (re_s),
      .raddr (raddr_s),
      .rdata (rd_data_o)
   );

   assign state_o    = state_r;
   assign done_o     = done_r;
   assign trig_idx_o = trig_idx_r;
   assign rd_valid_o = rd_valid_r;

endmodule

// File: tb/tb_sophon_trace_buf.sv
// Self-checking bench for sophon_trace_buf (PROBE_W=8, DEPTH=16) with a
// read-response scoreboard fed from the bench's own record of sampled probes.
module tb_sophon_trace_buf;

   localparam int W  = 8;
   localparam int D  = 16;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst, sample_en, arm, abort, force_trig, trig_edge, rd_req;
   logic [W-1:0]  probe, mask, val;
   logic [AW-1:0] pre_cnt, rd_idx;
   logic          rd_valid, done;
   logic [W-1:0]  rd_data;
   logic [2:0]    state;
   logic [AW-1:0] trig_idx;

   typedef struct {
      logic         v;
      logic [W-1:0] d;
   } exp_t;

   exp_t         exp_q[$];
   logic [W-1:0] hist[$];
   logic [W-1:0] last_d;
   bit           free_run, toggle_en;
   int           trig_pos;
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;

   sophon_trace_buf #(.PROBE_W(W), .DEPTH(D)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .probe_i      (probe),
      .sample_en_i  (sample_en),
      .arm_i        (arm),
      .abort_i      (abort),
      .force_trig_i (force_trig),
      .trig_mask_i  (mask),
      .trig_val_i   (val),
      .trig_edge_i  (trig_edge),
      .pre_cnt_i    (pre_cnt),
      .rd_req_i     (rd_req),
      .rd_idx_i     (rd_idx),
      .rd_valid_o   (rd_valid),
      .rd_data_o    (rd_data),
      .state_o      (state),
      .done_o       (done),
      .trig_idx_o   (trig_idx)
   );

   task automatic tick();
      logic pend;
      exp_t e;
      if (sample_en) hist.push_back(probe);
      pend = rd_req;
      @(posedge clk);
      #1;
      if (pend) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_scoreboard: response with empty queue, got valid=%0b data=%02h", rd_valid, rd_data);
         end else begin
            e = exp_q.pop_front();
            if (rd_valid !== e.v || rd_data !== e.d) begin
               errors++;
               $display("FAIL rd_response: got valid=%0b data=%02h, expected valid=%0b data=%02h",
                        rd_valid, rd_data, e.v, e.d);
            end
         end
      end
      if (free_run) probe = probe + 8'd1;
      if (toggle_en) sample_en = ~sample_en;
   endtask

   task automatic push_rd(input logic [AW-1:0] idx, input logic v, input logic [W-1:0] d);
      exp_t e;
      rd_req = 1'b1;
      rd_idx = idx;
      e.v = v;
      e.d = d;
      exp_q.push_back(e);
      if (v) last_d = d;
   endtask

   task automatic arm_cap(input logic [AW-1:0] p);
      pre_cnt = p;
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int n);
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done_timeout: done=%0b after %0d cycles, expected 1", done, n);
      end
   endtask

   // Back-to-back reads of all 16 indices; expected from a base value or the sample history.
   task automatic do_reads(input int pre_v, input bit use_base, input logic [W-1:0] base);
      logic [W-1:0] ex;
      for (int i = 0; i < D; i++) begin
         ex = use_base ? (base + 8'(i)) : hist[trig_pos - pre_v + i];
         push_rd(AW'(i), 1'b1, ex);
         tick();
      end
      rd_req = 1'b0;
      tick();
   endtask

   task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      checks++;
      if (state !== 3'd0 || done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00 || trig_idx !== 4'd0) begin
         errors++;
         $display("FAIL %s: got state=%0d done=%0b valid=%0b data=%02h trig_idx=%0d, expected all 0",
                  tag, state, done, rd_valid, rd_data, trig_idx);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      check_zero_outputs("reset_outputs");
      rst = 1'b0;
      last_d = 8'h00;
   endtask

   task automatic test_level();
      int n;
      mask = 8'hFF; val = 8'hA5; trig_edge = 1'b0;
      sample_en = 1'b1; free_run = 1'b1; probe = 8'h90;
      arm_cap(4'd4);
      while (probe != 8'hA5) tick();
      chk3("level_wait_state", state, 3'd2);
      tick();
      chk3("level_post_state", state, 3'd3);
      wait_done(40, n);
      checks++;
      if (n != 11) begin
         errors++;
         $display("FAIL level_done_latency: got %0d cycles, expected 11", n);
      end
      chk3("level_done_state", state, 3'd4);
      checks++;
      if (trig_idx !== 4'd4) begin
         errors++;
         $display("FAIL level_trig_idx: got %0d, expected 4", trig_idx);
      end
      do_reads(4, 1'b1, 8'hA1);
   endtask

   task automatic test_edge();
      int n;
      mask = 8'hFF; val = 8'hA5; trig_edge = 1'b1;
      free_run = 1'b0; probe = 8'hA5;
      arm_cap(4'd2);
      repeat (8) tick();
      chk3("edge_held_no_trig", state, 3'd2);
      probe = 8'h00;
      tick();
      probe = 8'hA5;
      tick();
      trig_pos = hist.size() - 1;
      chk3("edge_rise_trig", state, 3'd3);
      wait_done(30, n);
      checks++;
      if (trig_idx !== 4'd2) begin
         errors++;
         $display("FAIL edge_trig_idx: got %0d, expected 2", trig_idx);
      end
      do_reads(2, 1'b0, 8'h00);
      trig_edge = 1'b0;
   endtask

   task automatic test_force();
      mask = 8'hFF; val = 8'hFF; free_run = 1'b1; probe = 8'h10;
      arm_cap(4'd15);
      checks++;
      if (done !== 1'b0 || state !== 3'd1) begin
         errors++;
         $display("FAIL force_rearm: got done=%0b state=%0d, expected done=0 state=1", done, state);
      end
      repeat (20) tick();
      force_trig = 1'b1;
      tick();
      force_trig = 1'b0;
      checks++;
      if (done !== 1'b1 || trig_idx !== 4'd15) begin
         errors++;
         $display("FAIL force_done_next: got done=%0b trig_idx=%0d, expected done=1 trig_idx=15", done, trig_idx);
      end
      do_reads(15, 1'b1, 8'h16);
   endtask

   task automatic test_sample_en();
      int n;
      mask = 8'hFF; val = 8'hA5; free_run = 1'b1; probe = 8'h80;
      sample_en = 1'b1; toggle_en = 1'b1;
      arm_cap(4'd2);
      while (probe != 8'hB0) tick();
      chk3("sample_en_odd_no_trig", state, 3'd2);
      val = 8'hB4;
      while (probe != 8'hB4) tick();
      tick();
      trig_pos = hist.size() - 1;
      wait_done(80, n);
      toggle_en = 1'b0;
      sample_en = 1'b1;
      checks++;
      if (trig_idx !== 4'd2) begin
         errors++;
         $display("FAIL sample_en_trig_idx: got %0d, expected 2", trig_idx);
      end
      do_reads(2, 1'b0, 8'h00);
   endtask

   task automatic test_abort();
      mask = 8'hFF; val = 8'hA5; free_run = 1'b1; probe = 8'h90;
      arm_cap(4'd4);
      while (probe != 8'hA5) tick();
      tick();
      tick();
      chk3("abort_pre_state", state, 3'd3);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (state !== 3'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: got state=%0d done=%0b, expected state=0 done=0", state, done);
      end
      push_rd(4'd3, 1'b0, last_d);
      tick();
      rd_req = 1'b0;
      arm = 1'b1;
      abort = 1'b1;
      tick();
      arm = 1'b0;
      abort = 1'b0;
      chk3("abort_beats_arm", state, 3'd0);
   endtask

   task automatic test_reset_mid();
      mask = 8'hFF; val = 8'hA5; free_run = 1'b1; probe = 8'h10;
      arm_cap(4'd4);
      repeat (8) tick();
      chk3("midreset_wait_state", state, 3'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_zero_outputs("midreset_outputs");
      last_d = 8'h00;
      test_level();
   endtask

   initial begin
      rst = 1'b1; sample_en = 1'b1; arm = 1'b0; abort = 1'b0; force_trig = 1'b0;
      trig_edge = 1'b0; rd_req = 1'b0; probe = 8'h00; mask = 8'hFF; val = 8'hA5;
      pre_cnt = 4'd0; rd_idx = 4'd0; free_run = 1'b1; toggle_en = 1'b0;
      last_d = 8'h00; trig_pos = 0;
      test_reset();
      test_level();
      test_edge();
      test_force();
      test_sample_en();
      test_abort();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
